// File: rtl/stuff_tx.sv
// Serial bit-stuffing transmitter: shifts a WIDTH-bit word out MSB first and inserts a 0 after MAX_RUN consecutive 1s.
// Latency: first data bit on y one cycle after load is accepted; a word takes WIDTH + (stuffed bits) cycles.
// Backpressure: ready is high only in IDLE; load while busy is ignored and din is not sampled.
module stuff_tx #(
  parameter int WIDTH   = 8,
  parameter int MAX_RUN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             y,
  output logic             y_vld,
  output logic             stuffed,
  output logic             done
);

  // Counter widths sized for 0..WIDTH-1 and 0..MAX_RUN
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (MAX_RUN > 0) ? $clog2(MAX_RUN + 1) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(MAX_RUN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bit_cnt;
  logic [RW-1:0]    run_cnt;

  logic cur_bit;
  logic last_bit;
  logic run_full;

  // Bit currently on the line, end-of-word and "this 1 completes a full run"
  assign cur_bit  = sreg[WIDTH-1];
  assign last_bit = (bit_cnt == BIT_LAST);
  assign run_full = cur_bit && (run_cnt == RUN_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the last bit of a word never triggers a stuff
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        state_nxt = load ? SEND : IDLE;
      end
      SEND: begin
        if (last_bit) begin
          state_nxt = IDLE;
        end else if (run_full) begin
          state_nxt = STUFF;
        end else begin
          state_nxt = SEND;
        end
      end
      STUFF: begin
        state_nxt = SEND;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from state and counters
  always_comb begin
    ready   = 1'b1;
    y       = 1'b0;
    y_vld   = 1'b0;
    stuffed = 1'b0;
    done    = 1'b0;
    case (state)
      SEND: begin
        ready = 1'b0;
        y     = cur_bit;
        y_vld = 1'b1;
        done  = last_bit;
      end
      STUFF: begin
        ready   = 1'b0;
        y_vld   = 1'b1;
        stuffed = 1'b1;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

  // Datapath: shift register, bit counter and run-of-ones counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      run_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          run_cnt <= '0;
          if (load) begin
            sreg    <= din;
            bit_cnt <= '0;
          end
        end
        SEND: begin
          sreg    <= {sreg[WIDTH-2:0], 1'b0};
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          run_cnt <= cur_bit ? run_cnt + 1'b1 : '0;
        end
        STUFF: begin
          run_cnt <= '0;
        end
        default: begin
          run_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stuff_tx.sv
// Directed bench for stuff_tx: two instances (MAX_RUN=2 and MAX_RUN=1) share clock and reset.
// Inputs change #1 after the rising edge or at the falling edge; outputs are sampled on the falling edge.
// Each scenario task compares captured streams against hand-computed bit patterns.
module tb_stuff_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din0 = 8'h00;
  logic [7:0] din1 = 8'h00;
  logic       load0 = 1'b0;
  logic       load1 = 1'b0;
  logic       sel = 1'b0;

  logic rdy0, y0, v0, s0, d0;
  logic rdy1, y1, v1, s1, d1;
  logic m_rdy, m_y, m_vld, m_s, m_done;

  int total = 0;
  int bad   = 0;

  // Captured word
  logic [31:0] g_y;
  logic [31:0] g_s;
  int          g_n;
  int          g_dpos;
  int          g_dcnt;
  int          g_rdy;
  logic        g_to;
  logic        g_idle_rdy;

  // Stream table: din, instance, length, y bits, stuffed bits (first cycle = MSB)
  logic [7:0]  t_din [4] = '{8'hFF, 8'hB6, 8'h00, 8'hFF};
  logic        t_sel [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  int          t_n   [4] = '{11, 10, 8, 15};
  logic [31:0] t_y   [4] = '{32'b11011011011, 32'b1011001100, 32'b0, 32'b101010101010101};
  logic [31:0] t_s   [4] = '{32'b00100100100, 32'b0000100010, 32'b0, 32'b010101010101010};

  stuff_tx #(.WIDTH(8), .MAX_RUN(2)) dut (
    .clk(clk), .rst(rst), .din(din0), .load(load0),
    .ready(rdy0), .y(y0), .y_vld(v0), .stuffed(s0), .done(d0)
  );

  stuff_tx #(.WIDTH(8), .MAX_RUN(1)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .load(load1),
    .ready(rdy1), .y(y1), .y_vld(v1), .stuffed(s1), .done(d1)
  );

  always #5 clk = ~clk;

  assign m_rdy  = sel ? rdy1 : rdy0;
  assign m_y    = sel ? y1   : y0;
  assign m_vld  = sel ? v1   : v0;
  assign m_s    = sel ? s1   : s0;
  assign m_done = sel ? d1   : d0;

  // Load one word into the selected instance and capture its stream until IDLE.
  // With poke set, instance 0 gets a one-cycle load of pd during its third bit.
  task automatic run_word(input logic s, input logic [7:0] d, input logic poke, input logic [7:0] pd);
    sel = s;
    @(posedge clk); #1;
    if (s) begin din1 = d; load1 = 1'b1; end
    else   begin din0 = d; load0 = 1'b1; end
    @(posedge clk); #1;
    load0 = 1'b0; load1 = 1'b0;
    g_y = '0; g_s = '0; g_n = 0; g_dpos = 0; g_dcnt = 0; g_rdy = 0;
    g_to = 1'b1; g_idle_rdy = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      load0 = 1'b0;
      if (m_done) g_dcnt++;
      if (m_vld) begin
        g_y = {g_y[30:0], m_y};
        g_s = {g_s[30:0], m_s};
        g_n++;
        if (m_done) g_dpos = g_n;
        if (m_rdy) g_rdy++;
        if (poke && g_n == 3) begin din0 = pd; load0 = 1'b1; end
      end else if (g_n > 0) begin
        g_to = 1'b0;
        g_idle_rdy = m_rdy;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #12;
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL reset_ready0 got %b want 1", rdy0); end
    total++; if (y0 !== 1'b0)   begin bad++; $display("FAIL reset_y0 got %b want 0", y0); end
    total++; if (v0 !== 1'b0)   begin bad++; $display("FAIL reset_vld0 got %b want 0", v0); end
    total++; if (s0 !== 1'b0)   begin bad++; $display("FAIL reset_stuffed0 got %b want 0", s0); end
    total++; if (d0 !== 1'b0)   begin bad++; $display("FAIL reset_done0 got %b want 0", d0); end
    total++; if ({rdy1, y1, v1, s1, d1} !== 5'b10000) begin
      bad++; $display("FAIL reset_inst1 got %b want 10000", {rdy1, y1, v1, s1, d1});
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    total++; if ({rdy0, v0} !== 2'b10) begin bad++; $display("FAIL after_reset_idle got %b want 10", {rdy0, v0}); end
  endtask

  task automatic test_streams;
    for (int i = 0; i < 4; i++) begin
      run_word(t_sel[i], t_din[i], 1'b0, 8'h00);
      total++; if (g_to !== 1'b0) begin bad++; $display("FAIL stream%0d_timeout got %b want 0", i, g_to); end
      total++; if (g_n !== t_n[i]) begin bad++; $display("FAIL stream%0d_len got %0d want %0d", i, g_n, t_n[i]); end
      total++; if (g_y !== t_y[i]) begin bad++; $display("FAIL stream%0d_y got %b want %b", i, g_y, t_y[i]); end
      total++; if (g_s !== t_s[i]) begin bad++; $display("FAIL stream%0d_stuffed got %b want %b", i, g_s, t_s[i]); end
      total++; if (g_dpos !== t_n[i]) begin bad++; $display("FAIL stream%0d_done_pos got %0d want %0d", i, g_dpos, t_n[i]); end
      total++; if (g_dcnt !== 1) begin bad++; $display("FAIL stream%0d_done_cnt got %0d want 1", i, g_dcnt); end
      total++; if (g_rdy !== 0) begin bad++; $display("FAIL stream%0d_ready_busy got %0d want 0", i, g_rdy); end
      total++; if (g_idle_rdy !== 1'b1) begin bad++; $display("FAIL stream%0d_ready_idle got %b want 1", i, g_idle_rdy); end
    end
  endtask

  task automatic test_load_ignored;
    run_word(1'b0, 8'hB6, 1'b1, 8'h00);
    total++; if (g_n !== 10) begin bad++; $display("FAIL ignore_len got %0d want 10", g_n); end
    total++; if (g_y !== 32'b1011001100) begin bad++; $display("FAIL ignore_y got %b want 1011001100", g_y); end
    total++; if (g_s !== 32'b0000100010) begin bad++; $display("FAIL ignore_stuffed got %b want 0000100010", g_s); end
    total++; if (g_dpos !== 10) begin bad++; $display("FAIL ignore_done_pos got %0d want 10", g_dpos); end
  endtask

  // load held high: each word is followed by exactly one idle cycle
  task automatic test_back_to_back;
    logic [17:0] by;
    logic [17:0] bv;
    sel = 1'b0;
    by = '0; bv = '0;
    @(posedge clk); #1;
    din0 = 8'h81; load0 = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      by = {by[16:0], y0};
      bv = {bv[16:0], v0};
    end
    load0 = 1'b0;
    total++; if (by !== 18'b100000010100000010) begin bad++; $display("FAIL b2b_y got %b want 100000010100000010", by); end
    total++; if (bv !== 18'b111111110111111110) begin bad++; $display("FAIL b2b_vld got %b want 111111110111111110", bv); end
    repeat (12) @(negedge clk);
    total++; if (v0 !== 1'b0) begin bad++; $display("FAIL b2b_settle got %b want 0", v0); end
  endtask

  task automatic test_reset_mid;
    int nv;
    int late;
    sel = 1'b0;
    nv = 0;
    @(posedge clk); #1;
    din0 = 8'hFF; load0 = 1'b1;
    @(posedge clk); #1;
    load0 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (v0) nv++;
      if (nv == 5) break;
    end
    total++; if (nv !== 5) begin bad++; $display("FAIL midrst_reach got %0d want 5", nv); end
    #2 rst = 1'b0;
    #1;
    total++; if (v0 !== 1'b0)   begin bad++; $display("FAIL midrst_vld got %b want 0", v0); end
    total++; if (y0 !== 1'b0)   begin bad++; $display("FAIL midrst_y got %b want 0", y0); end
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL midrst_ready got %b want 1", rdy0); end
    total++; if ({s0, d0} !== 2'b00) begin bad++; $display("FAIL midrst_flags got %b want 00", {s0, d0}); end
    @(posedge clk);
    @(negedge clk); #1 rst = 1'b1;
    late = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (v0) late++;
    end
    total++; if (late !== 0) begin bad++; $display("FAIL midrst_leftover got %0d want 0", late); end
    run_word(1'b0, 8'h0F, 1'b0, 8'h00);
    total++; if (g_n !== 9) begin bad++; $display("FAIL post_rst_len got %0d want 9", g_n); end
    total++; if (g_y !== 32'b000011011) begin bad++; $display("FAIL post_rst_y got %b want 000011011", g_y); end
    total++; if (g_s !== 32'b000000100) begin bad++; $display("FAIL post_rst_stuffed got %b want 000000100", g_s); end
    total++; if (g_dpos !== 9) begin bad++; $display("FAIL post_rst_done_pos got %0d want 9", g_dpos); end
  endtask

  initial begin
    test_reset;
    test_streams;
    test_load_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stuff_tx.md
STUFF_TX -- requirements
Module: stuff_tx

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (WIDTH >= 2).
REQ-002 Parameter MAX_RUN, default 2, maximum consecutive data 1s on the line before a stuffed 0 is forced (1 <= MAX_RUN < WIDTH).
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 din  input  WIDTH  parallel word to transmit, sampled on load acceptance.
REQ-006 load  input  1  request to transmit din; accepted only when ready=1.
REQ-007 ready  output  1  high when the block can accept a word.
REQ-008 y  output  1  serial line, MSB first.
REQ-009 y_vld  output  1  high in every cycle y carries a data or stuffed bit.
REQ-010 stuffed  output  1  high in cycles where y is an inserted 0.
REQ-011 done  output  1  one-cycle pulse during the cycle the last data bit is on y.

Function
REQ-012 The FSM SHALL have three states: IDLE, SEND and STUFF.
REQ-013 IDLE: ready=1, y=0, y_vld=0, stuffed=0, done=0.
REQ-014 IDLE with load=1 at a rising edge SHALL capture din into the shift register, clear the bit and run counters, and enter SEND; first data bit (din[WIDTH-1]) appears on y the cycle after acceptance.
REQ-015 SEND and STUFF: ready=0 and load ignored; din not sampled.
REQ-016 SEND: y = shift register MSB, y_vld=1, stuffed=0; each edge shifts left by one and increments the bit counter.
REQ-017 Run counter in SEND: data bit 1 increments it; data bit 0 clears it.
REQ-018 SEND transition: if the current bit is the last (bit counter = WIDTH-1), next state IDLE, no stuffing; else if the bit is 1 and the run count reaches MAX_RUN, next state STUFF; else remain in SEND.
REQ-019 STUFF: exactly one cycle, y=0, y_vld=1, stuffed=1; clears the run counter; next state SEND; bit counter and shift register hold.
REQ-020 done SHALL be 1 only in the SEND cycle where the bit counter = WIDTH-1, combinationally derived from state and counter.
REQ-021 The run counter SHALL clear in IDLE; words are separated by at least one IDLE cycle (y=0), so no run spans words.
REQ-022 A word SHALL occupy WIDTH + S consecutive y_vld cycles, S = number of inserted stuff bits; no gaps within a word.
REQ-023 Guarantee: while y_vld=1, y SHALL never carry more than MAX_RUN consecutive 1s.
REQ-024 Counter widths SHALL hold values 0..WIDTH-1 and 0..MAX_RUN without overflow.
REQ-025 States outside the three defined SHALL transition to IDLE on the next edge.

Reset
REQ-026 rst=0 SHALL immediately, independent of clk, force state IDLE and clear the shift register, bit counter and run counter.
REQ-027 Output values during and after reset: ready=1, y=0, y_vld=0, stuffed=0, done=0.
REQ-028 Reset asserted mid-word SHALL abandon the word; no remaining bits emitted after release.
REQ-029 After rst returns high, the first load is accepted at the next rising edge.

Verification
REQ-030 MAX_RUN=2, din=8'hFF -> y over 11 y_vld cycles = 1,1,0,1,1,0,1,1,0,1,1; stuffed high in cycles 3,6,9; done in cycle 11; then IDLE, ready=1.
REQ-031 MAX_RUN=2, din=8'hB6 -> 10 cycles: 1,0,1,1,0,0,1,1,0,0; stuffed in cycles 5 and 9; done in cycle 10.
REQ-032 din=8'h00 -> 8 cycles all 0, stuffed never high, done in cycle 8.
REQ-033 MAX_RUN=1, din=8'hFF -> 15 cycles alternating 1,0, ending with 1; 7 stuffed bits.
REQ-034 load pulsed while in SEND with a different din -> ignored; output stream of the current word unchanged.
REQ-035 rst low for 1 cycle at data bit 4 of 8'hFF -> y=0, y_vld=0, ready=1 immediately; new load of 8'h0F after release -> 0,0,0,0,1,1,0,1,1 correctly.
